// File: rtl/bin_to_ascii_int_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ascii_pkg
// Description : Shared definitions for the binary-to-ASCII decimal printer:
//               ASCII code points, the controller state encoding and a
//               helper that sizes the BCD digit count for a binary width.
// Revision    : 1.0 - initial release
// ============================================================================
package ascii_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    SIGN    = 2'd2,
    EMIT    = 2'd3
  } state_e;

  // Number of decimal digits needed to print 2^width-1.
  function automatic int digits_for_width(input int width);
    longint unsigned v;
    int              n;
    v = (width >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << width) - 64'd1);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      if (v >= 64'd10) begin
        v = v / 64'd10;
        n = n + 1;
      end
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin_to_ascii_int_bcd_add3.sv
`default_nettype none
// ============================================================================
// Module      : bcd_add3
// Description : Double-dabble nibble correction. A BCD digit of 5 or more
//               gets 3 added so the following left shift carries correctly
//               into the next decimal digit.
// Ports       : nib - BCD digit before correction
//               adj - corrected digit
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_add3 (
  input  logic [3:0] nib,
  output logic [3:0] adj
);

  assign adj = (nib >= 4'd5) ? (nib + 4'd3) : nib;

endmodule
`default_nettype wire

// File: rtl/bin_to_ascii_int.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_ascii_int
// Description : Prints an unsigned binary integer as ASCII decimal digits,
//               most significant first, leading zeros suppressed. A serial
//               double-dabble converter (BIN_WIDTH cycles) feeds a
//               valid/ready byte emitter.
//               Optional macro BIN_TO_ASCII_SIGNED_EN: treat bin as two's
//               complement and prefix negative numbers with '-'.
// Ports       : clk       - rising-edge clock
//               reset_n   - synchronous active-low reset
//               bin       - value to convert, sampled on in_valid & in_ready
//               in_valid  - bin is presented
//               in_ready  - idle and able to accept
//               out_data  - ASCII character
//               out_valid - out_data is valid
//               out_ready - downstream accepts out_data
//               out_last  - current byte is the final character
// Revision    : 1.0 - initial release
// ============================================================================
module bin_to_ascii_int
  import ascii_pkg::*;
#(
  parameter int BIN_WIDTH = 16,
  parameter int DIGITS    = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [BIN_WIDTH-1:0] bin,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last
);

  localparam int c_BCD_W = 4 * DIGITS;
  localparam int c_CNT_W = $clog2(BIN_WIDTH + 1);
  localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  generate
    if (DIGITS < digits_for_width(BIN_WIDTH)) begin : g_digits_check
      $error("bin_to_ascii_int: DIGITS too small to hold 2^BIN_WIDTH-1");
    end
  endgenerate

  state_e                       r_state;
  state_e                       w_next_state;
  logic [BIN_WIDTH-1:0]         r_shreg;
  logic [BIN_WIDTH-1:0]         w_mag;
  logic [c_BCD_W-1:0]           r_bcd;
  logic [c_BCD_W-1:0]           w_adj;
  logic [c_BCD_W+BIN_WIDTH-1:0] w_shifted;
  logic [c_CNT_W-1:0]           r_cnt;
  logic [c_IDX_W-1:0]           r_idx;
  logic [c_IDX_W-1:0]           w_lead_idx;
  logic [3:0]                   w_digit;
  logic                         w_accept;
  logic                         w_fire;
  logic                         w_neg_pending;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_fire   = out_valid && out_ready;

`ifdef BIN_TO_ASCII_SIGNED_EN
  logic r_neg;

  // Magnitude fits BIN_WIDTH unsigned bits, including -2^(BIN_WIDTH-1).
  assign w_mag         = bin[BIN_WIDTH-1] ? (-bin) : bin;
  assign w_neg_pending = r_neg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_neg <= 1'b0;
    end else if (w_accept) begin
      r_neg <= bin[BIN_WIDTH-1];
    end
  end
`else
  assign w_mag         = bin;
  assign w_neg_pending = 1'b0;
`endif

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_add3
      bcd_add3 u_add3 (
        .nib (r_bcd[4*i +: 4]),
        .adj (w_adj[4*i +: 4])
      );
    end
  endgenerate

  // The bit shifted out of the top digit is always zero when DIGITS is sized.
  assign w_shifted = {w_adj, r_shreg} << 1;

  // Highest nonzero digit; stays 0 for an all-zero value so "0" is printed.
  always_comb begin
    w_lead_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_bcd[4*i +: 4] != 4'h0) begin
        w_lead_idx = c_IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_digit = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == c_IDX_W'(i)) begin
        w_digit = r_bcd[4*i +: 4];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic. CONVERT spends BIN_WIDTH shift cycles plus one cycle
  // to locate the leading digit, giving BIN_WIDTH+1 cycles to first byte.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = CONVERT;
      CONVERT: if (r_cnt == '0) w_next_state = w_neg_pending ? SIGN : EMIT;
      SIGN:    if (w_fire) w_next_state = EMIT;
      EMIT:    if (w_fire && (r_idx == '0)) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_shreg <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shreg <= w_mag;
            r_bcd   <= '0;
            r_cnt   <= c_CNT_W'(BIN_WIDTH);
          end
        end
        CONVERT: begin
          if (r_cnt != '0) begin
            {r_bcd, r_shreg} <= w_shifted;
            r_cnt            <= r_cnt - 1'b1;
          end else begin
            r_idx <= w_lead_idx;
          end
        end
        EMIT: begin
          if (w_fire && (r_idx != '0)) begin
            r_idx <= r_idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs depend only on registered state, so they hold during stalls.
  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == EMIT) || (r_state == SIGN);
    out_data  = 8'h00;
    out_last  = 1'b0;
    case (r_state)
      EMIT: begin
        out_data = ASCII_ZERO + {4'h0, w_digit};
        out_last = (r_idx == '0);
      end
      SIGN: begin
        out_data = ASCII_MINUS;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_bin_to_ascii_int.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin_to_ascii_int
// Description : Self-checking bench for bin_to_ascii_int (16-bit, 5 digits).
//               Reference model prints the accepted value with $sformatf and
//               expects those characters after 17 cycles; directed cases pin
//               literal strings. Honours BIN_TO_ASCII_SIGNED_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_to_ascii_int;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] bin = 16'h0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;

  int  n_cmp = 0;
  int  n_fail = 0;
  int  cyc = 0;
  bit  chk_en = 1'b0;
  byte exp_q[$];
  byte got[$];
  int  t_acc = 0;
  int  acc_count = 0;
  int  first_lat = -1;
  bit  seen_first = 1'b0;

  bin_to_ascii_int #(
    .BIN_WIDTH (16),
    .DIGITS    (5)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bin       (bin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got %0d cycles expected completion", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endtask

  function automatic string model_str(input logic [15:0] b);
`ifdef BIN_TO_ASCII_SIGNED_EN
    return $sformatf("%0d", $signed(b));
`else
    return $sformatf("%0d", b);
`endif
  endfunction

  function automatic string got_str();
    string s = "";
    foreach (got[i]) s = {s, $sformatf("%c", got[i])};
    return s;
  endfunction

  // Model + compare: the model queue holds the characters still owed.
  always @(negedge clk) begin
    bit    exp_valid;
    bit    was_empty;
    string s;
    if (chk_en) begin
      exp_valid = (exp_q.size() > 0) && ((cyc - t_acc) >= 17);
      check("in_ready", in_ready, exp_q.size() == 0);
      check("out_valid", out_valid, exp_valid);
      if (exp_valid && out_valid) begin
        check("out_data", out_data, exp_q[0]);
        check("out_last", out_last, exp_q.size() == 1);
      end
      if (out_valid && !seen_first) begin
        first_lat  = cyc - t_acc;
        seen_first = 1'b1;
      end
      if (!reset_n) begin
        exp_q.delete();
      end else begin
        if (out_valid && out_ready) got.push_back(out_data);
        was_empty = (exp_q.size() == 0);
        if (exp_valid && out_ready) void'(exp_q.pop_front());
        if (was_empty && in_valid) begin
          s = model_str(bin);
          for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
          t_acc      = cyc + 1;
          acc_count  = acc_count + 1;
          seen_first = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [15:0] v);
    int start = acc_count;
    bin      = v;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && acc_count == start; i++) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("send_accepted", acc_count - start, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_reached", exp_q.size(), 0);
  endtask

  task automatic run_number(input logic [15:0] v, input string exp);
    got.delete();
    out_ready = 1'b1;
    send(v);
    wait_idle();
    check_str($sformatf("string_%0d", v), got_str(), exp);
  endtask

  initial begin
    bit   pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int   start;
    int   n;

    // Reset
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_last", out_last, 0);
    check("rst_in_ready", in_ready, 1);

    // Zero: single "0", 17-cycle latency, ready right after
    run_number(16'd0, "0");
    check("zero_latency", first_lat, 17);
    check("ready_after_last", in_ready, 1);

`ifdef BIN_TO_ASCII_SIGNED_EN
    run_number(16'hFFFF, "-1");
    run_number(16'h8000, "-32768");
    run_number(16'h7FFF, "32767");
`else
    run_number(16'hFFFF, "65535");
    run_number(16'd32768, "32768");
    run_number(16'd100, "100");
`endif

    // 1004 with stalls
    got.delete();
    out_ready = 1'b0;
    send(16'd1004);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("stall_first_valid", out_valid, 1);
    foreach (pat[i]) begin
      out_ready = pat[i];
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_idle();
    check_str("stall_1004", got_str(), "1004");

    // Back-to-back 7 then 42 with in_valid held high
    got.delete();
    out_ready = 1'b1;
    start     = acc_count;
    bin       = 16'd7;
    in_valid  = 1'b1;
    n = 0;
    while (acc_count < start + 1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    bin = 16'd42;
    n = 0;
    while (acc_count < start + 2 && n < 80) begin
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    check("b2b_accepts", acc_count - start, 2);
    wait_idle();
    check_str("b2b_742", got_str(), "742");

    // Reset after the second byte of 12345
    got.delete();
    out_ready = 1'b1;
    send(16'd12345);
    n = 0;
    while (got.size() < 2 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    repeat (25) begin
      @(posedge clk); #1;
    end
    check_str("abort_12", got_str(), "12");
    run_number(16'd9, "9");

    // Random traffic: random in_valid (also while busy), values, out_ready
    for (int i = 0; i < 1500; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       bin = 16'h0000;
        1:       bin = 16'hFFFF;
        2:       bin = 16'h8000;
        3:       bin = 16'h7FFF;
        4:       bin = 16'($urandom_range(0, 9));
        default: bin = 16'($urandom);
      endcase
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bin_to_ascii_int.md
Name: bin_to_ascii_int

Overview:
- Converts an unsigned binary integer into a stream of ASCII decimal digit bytes, most significant digit first, with leading zeros suppressed.
- Used on the host-bound text path to print numeric fields (depth, nodes, score cp, move counts) into UCI response lines.
- Counterpart of the ASCII-digit-to-binary accumulator on the receive path.
- Conversion is a bit-serial double-dabble, followed by a valid/ready byte emitter.

Parameters:
- BIN_WIDTH, 16, width of the binary input.
- DIGITS, 5, BCD digit slots; must satisfy 10^DIGITS > 2^BIN_WIDTH-1 (elaboration assertion).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous reset, active-low; sampled on posedge clk.
- bin  in  BIN_WIDTH  value to convert; sampled on the input handshake.
- in_valid  in  1  bin is presented.
- in_ready  out  1  block idle and able to accept.
- out_data  out  8  ASCII character.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- out_last  out  1  current byte is the final character of the number.

Behaviour:
- Reset (reset_n low at a posedge): state IDLE, BCD register cleared, out_valid=0, out_data=8'h00, out_last=0. in_ready=1 from the first cycle after reset_n is sampled low. Inputs are ignored while reset_n is low.
- Reset mid-conversion or mid-emission aborts the number; no further bytes are emitted for it.
- States:
  - IDLE: in_ready=1, out_valid=0. On in_valid&in_ready, latch bin into a shift register, clear BCD, load cycle counter with BIN_WIDTH, go to CONVERT.
  - CONVERT: in_ready=0. Each cycle:
    - add 3 to every BCD nibble that is >=5;
    - shift {BCD, shift reg} left by one;
    - decrement the counter.
  - After exactly BIN_WIDTH cycles, go to EMIT. On entry, the digit index is set to the highest nonzero nibble, or 0 if all nibbles are zero.
  - EMIT: out_valid=1, out_data=8'h30+BCD[idx], out_last=(idx==0). On out_valid&out_ready:
    - if idx==0, go to IDLE;
    - otherwise decrement idx.
  - out_data, out_last and idx stay stable while out_valid=1 and out_ready=0.
- Latency: first out_valid occurs exactly BIN_WIDTH+1 cycles after the accepting edge. in_ready returns high in the cycle after the last-byte handshake; there is no bubble beyond that cycle.
- Zero input emits the single byte "0" (8'h30) with out_last=1.
- Internal zeros are emitted (e.g. 100 emits "100"). Only leading zeros are suppressed.
- Maximum value 2^BIN_WIDTH-1 produces the full digit count (65535 gives 5 bytes at default parameters).
- in_valid asserted while busy is ignored (in_ready=0); the bin value is not re-sampled.
- out_ready held high gives one byte per cycle.

Optional Feature:
- Macro: BIN_TO_ASCII_SIGNED_EN.
- Defined:
  - bin is two's complement. The magnitude is computed on acceptance as (bin[MSB] ? -bin : bin), held in BIN_WIDTH unsigned bits; -2^(BIN_WIDTH-1) converts correctly.
  - A negative value first emits 8'h2D ('-') with out_last=0 from a SIGN state between CONVERT and EMIT. First-byte latency is unchanged; digit bytes follow.
  - Zero is never printed with a sign.
- Undefined: no SIGN state and unsigned interpretation only; behaviour is exactly as above.

Decomposition:
- Shared package (ascii_pkg) holds:
  - ASCII_ZERO=8'h30 and ASCII_MINUS=8'h2D;
  - the state enum {IDLE, CONVERT, SIGN, EMIT};
  - a function returning the required DIGITS for a BIN_WIDTH.
- One natural sub-module: bcd_add3 (combinational nibble correction, >=5 ? +3 : unchanged), instantiated DIGITS times.
- Control and emitter stay in the top module.

Test Plan:
- bin=0, out_ready=1: exactly one byte 8'h30 with out_last=1, first valid 17 cycles after accept; in_ready high the next cycle.
- bin=65535: bytes "6","5","5","3","5" on consecutive cycles; out_last only on the 5th.
- bin=1004 with out_ready toggled 1,0,0,1,0,1,1: bytes "1","0","0","4" each held stable while stalled; no drops or duplicates.
- Back-to-back 7 then 42 with in_valid held high: byte "7" (last), then 16 conversion cycles, then "4","2". in_valid during busy is ignored.
- Reset_n low for one cycle after the second byte of 12345: no further bytes; out_valid=0 and in_ready=1 after reset. Next input 9 emits "9" cleanly.
- BIN_TO_ASCII_SIGNED_EN defined:
  - -32768 gives "-","3","2","7","6","8";
  - -1 gives "-","1";
  - 0 gives "0" only;
  - 32767 gives no sign byte.
